prbs_frame_ctrl: RTL and testbench

Sequences the PRBS-23 bit generator into framed symbol bursts for the QAM mapper. Each frame is a fixed preamble, then PAYLOAD_LEN PRBS symbols, then an idle gap. Symbols are paced by a clock-divider symbol tick and presented to the mapper over a valid/ready handshake. The block sits between the PRBS generator (driving its enable, consuming its bits and valid strobe) and the mapper input.

---
 rtl/prbs_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_prbs_frame_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_frame_ctrl.sv
// rtl/prbs_frame_ctrl.sv - frames PRBS symbols into preamble/payload/gap bursts for the QAM mapper
// Optional build: define GDSP_FRAME_CNT_EN to include the completed-frame counter.
module prbs_frame_ctrl #(
  parameter int SYM_DIV = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int PAYLOAD_LEN = 256,
  parameter int GAP_LEN = 16,
  parameter int BITS_PER_SYM = 4,
  parameter logic [BITS_PER_SYM-1:0] PREAMBLE_PAT = 4'hA
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  output logic                    prbs_en,
  input  logic [BITS_PER_SYM-1:0] prbs_bits,
  input  logic                    prbs_valid,
  output logic [BITS_PER_SYM-1:0] sym_data,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_sof,
  output logic                    sym_eof,
  output logic                    busy,
  output logic                    late,
  output logic [15:0]             frame_cnt
);

  localparam int MAX_PG = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
  localparam int MAX_LEN = (PAYLOAD_LEN > MAX_PG) ? PAYLOAD_LEN : MAX_PG;
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int DIV_W = $clog2(SYM_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [DIV_W-1:0] div;
  logic             tick_pending;
  logic             stop_q;
  logic             outstanding;
  logic             req_eof;
  logic             tick, issue, start_acc, stop_any, gap_exit_idle;

  assign start_acc     = (state == S_IDLE) && start;
  assign tick          = (state != S_IDLE) && (div == DIV_LAST);
  assign issue         = (state != S_IDLE) && tick_pending && !sym_valid && !outstanding;
  assign stop_any      = stop_q || stop;
  assign gap_exit_idle = stop_any || !continuous;
  // outstanding keeps busy up while the last PRBS word is still in flight after state has gone IDLE
  assign busy          = (state != S_IDLE) || sym_valid || outstanding;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_PREAMBLE;
          idx_n   = '0;
        end
      end
      S_PREAMBLE: begin
        if (issue) begin
          if (idx == PRE_LAST) begin
            state_n = S_PAYLOAD;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (issue) begin
          if (idx == PAY_LAST) begin
            idx_n = '0;
            if (stop_any)          state_n = S_IDLE;
            else if (GAP_LEN == 0) state_n = continuous ? S_PREAMBLE : S_IDLE;
            else                   state_n = S_GAP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (issue) begin
          if (idx == GAP_LAST) begin
            idx_n   = '0;
            state_n = gap_exit_idle ? S_IDLE : S_PREAMBLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      div          <= '0;
      tick_pending <= 1'b0;
      late         <= 1'b0;
      stop_q       <= 1'b0;
      outstanding  <= 1'b0;
      req_eof      <= 1'b0;
      prbs_en      <= 1'b0;
      sym_data     <= '0;
      sym_valid    <= 1'b0;
      sym_sof      <= 1'b0;
      sym_eof      <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;

      if (state == S_IDLE || state_n == S_IDLE) div <= '0;
      else if (div == DIV_LAST)                 div <= '0;
      else                                      div <= div + 1'b1;

      // a tick landing on an issue cycle re-arms pending rather than being counted as late
      if (state_n == S_IDLE)  tick_pending <= 1'b0;
      else if (tick)          tick_pending <= 1'b1;
      else if (issue)         tick_pending <= 1'b0;

      if (start_acc)                            late <= 1'b0;
      else if (tick && tick_pending && !issue)  late <= 1'b1;

      if (state != S_IDLE && state_n == S_IDLE)         stop_q <= 1'b0;
      else if (stop && (state != S_IDLE || start_acc))  stop_q <= 1'b1;

      prbs_en <= issue && (state == S_PAYLOAD);

      if (issue && state == S_PAYLOAD) begin
        outstanding <= 1'b1;
        req_eof     <= (idx == PAY_LAST);
      end else if (outstanding && prbs_valid) begin
        outstanding <= 1'b0;
      end

      if (issue && state == S_PREAMBLE) begin
        sym_data  <= idx[0] ? ~PREAMBLE_PAT : PREAMBLE_PAT;
        sym_valid <= 1'b1;
        sym_sof   <= (idx == '0);
        sym_eof   <= 1'b0;
      end else if (outstanding && prbs_valid) begin
        sym_data  <= prbs_bits;
        sym_valid <= 1'b1;
        sym_sof   <= 1'b0;
        sym_eof   <= req_eof;
      end else if (sym_valid && sym_ready) begin
        sym_data  <= '0;
        sym_valid <= 1'b0;
        sym_sof   <= 1'b0;
        sym_eof   <= 1'b0;
      end
    end
  end

`ifdef GDSP_FRAME_CNT_EN
  logic [15:0] frame_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                              frame_q <= 16'd0;
    else if (sym_valid && sym_ready && sym_eof) frame_q <= frame_q + 16'd1;
  end
  assign frame_cnt = frame_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// tb/tb_prbs_frame_ctrl.sv - self-checking bench for prbs_frame_ctrl
module tb_prbs_frame_ctrl;

  localparam int SYM_DIV = 4;
  localparam int PRE = 2;
  localparam int PAY = 4;
  localparam int GAP = 3;
  localparam int FRAME_SYMS = PRE + PAY;
  localparam logic [3:0] PAT = 4'hA;
  // tick after SYM_DIV cycles, one cycle to pend/issue, one to register the symbol
  localparam int SOF_LAT = SYM_DIV + 2;
  localparam int BUSY_TAIL = (GAP - 1) * SYM_DIV + 2;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, continuous;
  logic        prbs_en;
  logic [3:0]  prbs_bits;
  logic        prbs_valid;
  logic [3:0]  sym_data;
  logic        sym_valid, sym_ready, sym_sof, sym_eof, busy, late;
  logic [15:0] frame_cnt;

  prbs_frame_ctrl #(
    .SYM_DIV(SYM_DIV), .PREAMBLE_LEN(PRE), .PAYLOAD_LEN(PAY), .GAP_LEN(GAP),
    .BITS_PER_SYM(4), .PREAMBLE_PAT(PAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .prbs_en(prbs_en), .prbs_bits(prbs_bits), .prbs_valid(prbs_valid),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_sof(sym_sof), .sym_eof(sym_eof), .busy(busy), .late(late), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PRBS-23 generator model (x^23 + x^18 + 1, MSB out, seed all ones)
  logic [22:0] lfsr = '1;
  logic        gen_next = 1'b0;
  logic        stray = 1'b0;
  logic [3:0]  gen_q[$];

  always @(negedge clk) begin
    logic [3:0] w;
    w = '0;
    if (gen_next) begin
      for (int b = 0; b < 4; b++) begin
        w = {w[2:0], lfsr[22]};
        lfsr = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
      end
      prbs_valid = 1'b1;
      prbs_bits  = w;
      gen_q.push_back(w);
    end else if (stray) begin
      prbs_valid = 1'b1;
      prbs_bits  = 4'h5;
      stray      = 1'b0;
    end else begin
      prbs_valid = 1'b0;
      prbs_bits  = 4'h0;
    end
    gen_next = (prbs_en === 1'b1);
  end

  // transfer monitor
  logic [5:0] obs_q[$];
  int         sof_cyc_q[$];
  int         eof_cyc_q[$];
  int         en_cyc_q[$];
  logic       hold_prev = 1'b0;
  logic [5:0] hold_word = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev)
        check_eq("hold_stable", {sym_valid, sym_sof, sym_eof, sym_data}, {1'b1, hold_word});
      if (sym_valid)
        check_eq("no_en_while_full", prbs_en, 1'b0);
      if (sym_valid && sym_ready) begin
        obs_q.push_back({sym_sof, sym_eof, sym_data});
        if (sym_sof) sof_cyc_q.push_back(cyc);
        if (sym_eof) eof_cyc_q.push_back(cyc);
      end
      if (prbs_en) en_cyc_q.push_back(cyc);
      hold_prev = sym_valid && !sym_ready;
      hold_word = {sym_sof, sym_eof, sym_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  logic rand_ready = 1'b0;
  int   exp_fc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) sym_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int when);
    int n;
    n = 0;
    while (busy && n < BUDGET) begin
      step();
      n++;
    end
    check_eq(tag, busy, 1'b0);
    when = cyc;
  endtask

  task automatic wait_sofs(input string tag, input int k);
    int n;
    n = 0;
    while (sof_cyc_q.size() < k && n < BUDGET) begin
      step();
      n++;
    end
    check_eq(tag, sof_cyc_q.size(), k);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    gen_q.delete();
    sof_cyc_q.delete();
    eof_cyc_q.delete();
    en_cyc_q.delete();
  endtask

  // expected stream: per frame, alternating preamble then the generator's words in order
  task automatic check_stream(input string tag, input int nframes);
    logic [5:0] exp_w;
    logic [3:0] pw;
    int k;
    k = 0;
    check_eq({tag, "_len"}, obs_q.size(), nframes * FRAME_SYMS);
    check_eq({tag, "_words"}, gen_q.size(), nframes * PAY);
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < FRAME_SYMS; i++) begin
        if (i < PRE) begin
          pw = (i % 2 == 1) ? ~PAT : PAT;
          exp_w = {(i == 0), 1'b0, pw};
        end else begin
          pw = (gen_q.size() > 0) ? gen_q.pop_front() : 4'h0;
          exp_w = {1'b0, (i == FRAME_SYMS - 1), pw};
        end
        if (k < obs_q.size()) check_eq({tag, "_sym"}, obs_q[k], exp_w);
        k++;
      end
    end
    exp_fc += nframes;
`ifdef GDSP_FRAME_CNT_EN
    check_eq({tag, "_frame_cnt"}, frame_cnt, 16'(exp_fc));
`else
    check_eq({tag, "_frame_cnt"}, frame_cnt, 16'd0);
`endif
    clear_obs();
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_prbs_en"}, prbs_en, 1'b0);
    check_eq({tag, "_sym_valid"}, sym_valid, 1'b0);
    check_eq({tag, "_sym_data"}, sym_data, 4'h0);
    check_eq({tag, "_sof"}, sym_sof, 1'b0);
    check_eq({tag, "_eof"}, sym_eof, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_late"}, late, 1'b0);
    check_eq({tag, "_frame_cnt"}, frame_cnt, 16'd0);
  endtask

  initial begin
    int c0, t_idle, n, k;
    logic [5:0] w0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; sym_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_quiet("reset");

    // single frame
    clear_obs();
    c0 = cyc;
    pulse_start();
    wait_idle("t1_idle", t_idle);
    check_eq("t1_sof_lat", (sof_cyc_q.size() > 0) ? sof_cyc_q[0] - c0 : -1, SOF_LAT);
    check_eq("t1_en_count", en_cyc_q.size(), PAY);
    for (int i = 1; i < en_cyc_q.size(); i++)
      check_eq("t1_en_spacing", en_cyc_q[i] - en_cyc_q[i-1], SYM_DIV);
    check_eq("t1_busy_tail", (eof_cyc_q.size() > 0) ? t_idle - eof_cyc_q[0] : -1, BUSY_TAIL);
    check_eq("t1_late", late, 1'b0);
    w0 = (obs_q.size() > PRE) ? obs_q[PRE] : 6'h0;
    check_eq("t1_first_word", w0[3:0], 4'hF);
    check_stream("t1", 1);

    // continuous, two frames
    continuous = 1'b1;
    pulse_start();
    wait_sofs("t2_sofs", 2);
    continuous = 1'b0;
    wait_idle("t2_idle", t_idle);
    check_eq("t2_sof_period", (sof_cyc_q.size() > 1) ? sof_cyc_q[1] - sof_cyc_q[0] : -1,
             SYM_DIV * (PRE + PAY + GAP));
    check_stream("t2", 2);

    // backpressure mid-payload
    pulse_start();
    n = 0;
    while (!(en_cyc_q.size() >= 2 && sym_valid) && n < BUDGET) begin
      step();
      n++;
    end
    check_eq("t3_reach_payload", sym_valid, 1'b1);
    sym_ready = 1'b0;
    repeat (20) step();
    check_eq("t3_late", late, 1'b1);
    check_eq("t3_en_stalled", en_cyc_q.size(), 2);
    sym_ready = 1'b1;
    wait_idle("t3_idle", t_idle);
    check_stream("t3", 1);

    // stop during preamble with continuous set
    continuous = 1'b1;
    pulse_start();
    check_eq("t4_late_cleared", late, 1'b0);
    wait_sofs("t4_sof", 1);
    pulse_stop();
    wait_idle("t4_idle", t_idle);
    check_eq("t4_no_gap", (eof_cyc_q.size() > 0) ? t_idle - eof_cyc_q[0] : -1, 1);
    repeat (60) step();
    check_eq("t4_one_sof", sof_cyc_q.size(), 1);
    check_eq("t4_stays_idle", busy, 1'b0);
    check_stream("t4", 1);

    // start and stop in the same idle cycle
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    wait_idle("t4b_idle", t_idle);
    repeat (60) step();
    check_stream("t4b", 1);
    continuous = 1'b0;

    // reset right after a payload prbs_en
    pulse_start();
    n = 0;
    while (!prbs_en && n < BUDGET) begin
      step();
      n++;
    end
    check_eq("t5_en_seen", prbs_en, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    stray = 1'b1;
    check_quiet("t5_after_rst");
    step();
    check_eq("t5_stray_ignored", sym_valid, 1'b0);
    check_eq("t5_stray_busy", busy, 1'b0);
    exp_fc = 0;
    clear_obs();
    c0 = cyc;
    pulse_start();
    wait_idle("t5_idle", t_idle);
    check_eq("t5_sof_lat", (sof_cyc_q.size() > 0) ? sof_cyc_q[0] - c0 : -1, SOF_LAT);
    check_stream("t5", 1);

    // randomized backpressure and frame counts
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(1, 3);
      continuous = 1'b1;
      rand_ready = 1'b1;
      pulse_start();
      wait_sofs("rnd_sofs", k);
      if ($urandom_range(0, 1) == 1) pulse_stop();
      else continuous = 1'b0;
      wait_idle("rnd_idle", t_idle);
      rand_ready = 1'b0;
      sym_ready = 1'b1;
      continuous = 1'b0;
      check_stream("rnd", k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
